rr_arbiter: RTL and testbench

//  Round-robin arbiter/controller: N requesters share one sequential resource (an FSM unit with a done

---
 rtl/rr_arbiter_if.sv | 24 ++
 rtl/rr_arbiter.sv | 106 ++++++++++
 tb/tb_rr_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_if.sv
// Requester-side bundle for the round-robin arbiter: request/done inputs and
// the registered grant, owner and watchdog outputs.
interface rr_arbiter_if #(
  parameter int N = 3
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic             busy;
  logic [IDX_W-1:0] owner;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, busy, owner, timeout
  );

  modport slave (
    input  req, done,
    output gnt, busy, owner, timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one shared sequential unit: one-hot registered grant,
// held until done or withdrawal, forcibly revoked by a MAX_HOLD-cycle watchdog.
module rr_arbiter #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  rr_arbiter_if.slave bus
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e           state_q;
  logic [N-1:0]     gnt_q;
  logic             busy_q;
  logic [IDX_W-1:0] owner_q;
  logic             timeout_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] last_q;

  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic [IDX_W-1:0] scan_idx;

  // Scan last+1, last+2, ... (mod N); the previous owner is checked last.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    arb_idx   = '0;
    arb_valid = 1'b0;
    scan_idx  = last_q;
    for (int i = 0; i < N; i++) begin
      scan_idx = (scan_idx == IDX_W'(N - 1)) ? '0 : scan_idx + IDX_W'(1);
      if (!arb_valid && bus.req[scan_idx]) begin
        arb_valid = 1'b1;
        arb_idx   = scan_idx;
      end
    end
  end

  // NOTE: all state updates use non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      last_q    <= IDX_W'(N - 1);
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, RELEASE: begin
          if (arb_valid) begin
            state_q <= GRANT;
            gnt_q   <= {{(N-1){1'b0}}, 1'b1} << arb_idx;
            busy_q  <= 1'b1;
            owner_q <= arb_idx;
            cnt_q   <= CNT_W'(1);
          end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
          end
        end

        GRANT: begin
          if (bus.done || !bus.req[owner_q] || (cnt_q == CNT_W'(MAX_HOLD))) begin
            state_q   <= RELEASE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            last_q    <= owner_q;
            owner_q   <= '0;
            cnt_q     <= '0;
            // Only a watchdog expiry flags timeout; done and withdrawal take precedence.
            timeout_q <= !bus.done && bus.req[owner_q];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          owner_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.owner   = owner_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed-vector bench for rr_arbiter (N=3, MAX_HOLD=8) with hand-computed
// expectations and a per-cycle one-hot/busy/owner consistency check.
module tb_rr_arbiter;
  localparam int N        = 3;
  localparam int MAX_HOLD = 8;

  logic clk;
  logic reset_n;
  logic run_chk;

  int n_vec  = 0;
  int n_miss = 0;

  rr_arbiter_if #(.N(N)) bus ();

  rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] g, input logic b,
                            input logic [1:0] o, input logic t);
    check({tag, ".gnt"},     32'(bus.gnt),     32'(g));
    check({tag, ".busy"},    32'(bus.busy),    32'(b));
    check({tag, ".owner"},   32'(bus.owner),   32'(o));
    check({tag, ".timeout"}, 32'(bus.timeout), 32'(t));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Invariants sampled on the falling edge, away from the update edge.
  always @(negedge clk) begin
    if (run_chk) begin
      check("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      check("busy_eq", 32'(bus.busy), 32'(|bus.gnt));
      if (bus.busy) check("owner_eq", 32'(bus.gnt), 32'(3'b001 << bus.owner));
    end
  end

  logic [2:0] t2_seq [4];

  initial begin
    run_chk  = 1'b0;
    reset_n  = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    t2_seq   = '{3'b001, 3'b010, 3'b100, 3'b001};

    // T1: reset, single requester, done release
    #2;
    expect_out("t1_reset", 3'b000, 1'b0, 2'd0, 1'b0);
    tick();
    reset_n = 1'b1;
    run_chk = 1'b1;
    tick();
    expect_out("t1_idle", 3'b000, 1'b0, 2'd0, 1'b0);
    bus.req = 3'b001;
    tick();
    expect_out("t1_grant", 3'b001, 1'b1, 2'd0, 1'b0);
    bus.done = 1'b1;
    tick();
    expect_out("t1_release", 3'b000, 1'b0, 2'd0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 3'b000;
    tick();
    expect_out("t1_back_idle", 3'b000, 1'b0, 2'd0, 1'b0);

    // T2: all request, done on 3rd grant cycle -> 001,010,100,001 with gaps
    do_reset();
    bus.req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        check("t2_gnt", 32'(bus.gnt), 32'(t2_seq[k]));
      end
      bus.done = 1'b1;
      tick();
      expect_out("t2_gap", 3'b000, 1'b0, 2'd0, 1'b0);
      bus.done = 1'b0;
    end
    bus.req = 3'b000;
    tick();
    expect_out("t2_idle", 3'b000, 1'b0, 2'd0, 1'b0);

    // T3: watchdog; last=0 so req=010 is granted, held MAX_HOLD cycles
    bus.req = 3'b010;
    for (int c = 0; c < MAX_HOLD; c++) begin
      tick();
      expect_out("t3_hold", 3'b010, 1'b1, 2'd1, 1'b0);
    end
    tick();
    expect_out("t3_timeout", 3'b000, 1'b0, 2'd0, 1'b1);
    tick();
    expect_out("t3_regrant", 3'b010, 1'b1, 2'd1, 1'b0);
    bus.req = 3'b000;
    tick();
    expect_out("t3_withdraw", 3'b000, 1'b0, 2'd0, 1'b0);
    tick();

    // T4: withdrawal on cycle 3 releases without timeout
    bus.req = 3'b100;
    tick();
    expect_out("t4_grant", 3'b100, 1'b1, 2'd2, 1'b0);
    tick();
    expect_out("t4_hold", 3'b100, 1'b1, 2'd2, 1'b0);
    bus.req = 3'b000;
    tick();
    expect_out("t4_release", 3'b000, 1'b0, 2'd0, 1'b0);
    tick();
    expect_out("t4_idle", 3'b000, 1'b0, 2'd0, 1'b0);

    // T5: asynchronous reset mid-grant, then req=101 favours req[0]
    bus.req = 3'b010;
    tick();
    expect_out("t5_grant", 3'b010, 1'b1, 2'd1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    expect_out("t5_async", 3'b000, 1'b0, 2'd0, 1'b0);
    bus.req = 3'b101;
    #1;
    reset_n = 1'b1;
    tick();
    expect_out("t5_first", 3'b001, 1'b1, 2'd0, 1'b0);

    // T6: done coincides with cnt==MAX_HOLD -> no timeout, next goes to req[2]
    for (int c = 1; c < MAX_HOLD; c++) tick();
    expect_out("t6_at_max", 3'b001, 1'b1, 2'd0, 1'b0);
    bus.done = 1'b1;
    tick();
    expect_out("t6_release", 3'b000, 1'b0, 2'd0, 1'b0);
    bus.done = 1'b0;
    tick();
    expect_out("t6_next", 3'b100, 1'b1, 2'd2, 1'b0);
    bus.req = 3'b000;
    tick();
    tick();
    expect_out("t6_idle", 3'b000, 1'b0, 2'd0, 1'b0);

    run_chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
